// File: rtl/pipelined_addsub_pkg.sv
// Shared ALU definitions for the pipelined adder/subtractor: flag bundle,
// op encoding and the elaboration-time parameter check.
package pipelined_addsub_pkg;

   typedef struct packed {
      logic c_out;
      logic ovf;
      logic zero;
   } alu_flags_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic bit stages_divide_width(input int unsigned width,
                                              input int unsigned stages);
      return (width >= 2) && (stages >= 1) && (stages <= width) &&
             ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipelined_addsub_chunk.sv
// CW-bit combinational ripple of full-adder cells; also exposes the carry
// into the chunk MSB so the last stage can form signed overflow.
module addsub_chunk #(
   parameter int unsigned CW = 8
) (
   input  logic [CW-1:0] i_a,
   input  logic [CW-1:0] i_b,
   input  logic          i_cin,
   output logic [CW-1:0] o_s,
   output logic          o_cout,
   output logic          o_cmsb
);

   logic [CW:0] w_c;

   always_comb begin
      w_c    = '0;
      o_s    = '0;
      w_c[0] = i_cin;
      for (int i = 0; i < int'(CW); i++) begin
         o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_cout = w_c[CW];
   assign o_cmsb = w_c[CW-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/sub with carry ripple split over STAGES register stages,
// global-stall valid/ready handshake and registered ALU flags.
module pipelined_addsub
   import pipelined_addsub_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   input  logic             sub,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned CW   = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   if (!stages_divide_width(WIDTH, STAGES)) begin : g_bad_params
      $error("pipelined_addsub: need WIDTH>=2, 1<=STAGES<=WIDTH, WIDTH%%STAGES==0");
   end

   logic             w_adv;
   logic             w_is_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;

   logic             r_v [STAGES];
   logic [WIDTH-1:0] r_a [STAGES];
   logic [WIDTH-1:0] r_b [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic             r_c [STAGES];
   alu_flags_t       r_flags;

   logic             w_v_in   [STAGES];
   logic [WIDTH-1:0] w_a_in   [STAGES];
   logic [WIDTH-1:0] w_b_in   [STAGES];
   logic [WIDTH-1:0] w_s_in   [STAGES];
   logic             w_c_in   [STAGES];
   logic [WIDTH-1:0] w_s_next [STAGES];
   logic [CW-1:0]    w_cs     [STAGES];
   logic             w_cout   [STAGES];
   logic             w_cmsb   [STAGES];

   // Whole pipeline moves together; only out_ready reaches in_ready combinationally.
   assign w_adv     = !r_v[LAST] || out_ready;
   assign in_ready  = w_adv;
   assign w_is_sub  = (sub == OP_SUB);
   assign w_b_eff   = in_2 ^ {WIDTH{w_is_sub}};
   assign w_cin_eff = c_in ^ w_is_sub;

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      localparam int unsigned LO = 32'(k) * CW;
      localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CW{1'b1}}) << LO;

      if (k == 0) begin : g_head
         assign w_v_in[k] = in_valid;
         assign w_a_in[k] = in_1;
         assign w_b_in[k] = w_b_eff;
         assign w_s_in[k] = '0;
         assign w_c_in[k] = w_cin_eff;
      end else begin : g_body
         assign w_v_in[k] = r_v[k-1];
         assign w_a_in[k] = r_a[k-1];
         assign w_b_in[k] = r_b[k-1];
         assign w_s_in[k] = r_s[k-1];
         assign w_c_in[k] = r_c[k-1];
      end

      addsub_chunk #(.CW(CW)) u_chunk (
         .i_a    (w_a_in[k][LO +: CW]),
         .i_b    (w_b_in[k][LO +: CW]),
         .i_cin  (w_c_in[k]),
         .o_s    (w_cs[k]),
         .o_cout (w_cout[k]),
         .o_cmsb (w_cmsb[k])
      );

      // Lower result chunks travel forward; this stage fills in its own slice.
      assign w_s_next[k] = (w_s_in[k] & ~CHUNK_MASK) | (WIDTH'(w_cs[k]) << LO);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_v[k] <= 1'b0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
         end else if (w_adv) begin
            r_v[k] <= w_v_in[k];
            r_s[k] <= w_s_next[k];
            r_c[k] <= w_cout[k];
         end
      end

      if (k < int'(LAST)) begin : g_skew
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_a[k] <= '0;
               r_b[k] <= '0;
            end else if (w_adv) begin
               r_a[k] <= w_a_in[k];
               r_b[k] <= w_b_in[k];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= '0;
      end else if (w_adv) begin
         r_flags.c_out <= w_cout[LAST];
         r_flags.ovf   <= w_cout[LAST] ^ w_cmsb[LAST];
         r_flags.zero  <= ~|w_s_next[LAST];
      end
   end

   assign out_valid = r_v[LAST];
   assign sum       = r_s[LAST];
   assign c_out     = r_flags.c_out;
   assign ovf       = r_flags.ovf;
   assign zero      = r_flags.zero;

endmodule
